// File: rtl/prio_encoder83_pkg.sv
// Shared sizes and FSM state encodings for the 8-to-3 priority encoder.
package prio_encoder83_pkg;

   localparam int N_REQ  = 8;
   localparam int CODE_W = 3;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

endpackage

// File: rtl/prio_enc8_comb.sv
// Combinational 8-bit priority encoder; HIGH_FIRST picks which end of the vector wins.
module prio_enc8_comb
   import prio_encoder83_pkg::*;
#(
   parameter bit HIGH_FIRST = 1'b1
) (
   input  logic [N_REQ-1:0]  in,
   output logic [CODE_W-1:0] code,
   output logic              any
);

   // Later assignments win, so scan toward the priority end.
   always_comb begin
      code = '0;
      any  = |in;
      if (HIGH_FIRST) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (in[k]) code = CODE_W'(k);
         end
      end else begin
         for (int k = N_REQ - 1; k >= 0; k--) begin
            if (in[k]) code = CODE_W'(k);
         end
      end
   end

endmodule

// File: rtl/prio_encoder83.sv
// Sticky request capture with a valid/ready code output, one code per handshake.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | out_valid low; encodes registered pending when it is nonzero
//   ST_PRESENT | out_valid high, out_code frozen until out_ready consumes it
module prio_encoder83
   import prio_encoder83_pkg::*;
#(
   parameter bit HIGH_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [CODE_W-1:0] out_code,
   output logic [N_REQ-1:0]  pending,
   output logic              overflow
);

   state_t            state;
   logic [CODE_W-1:0] enc_code;
   logic              enc_any;
   logic [N_REQ-1:0]  clr_mask;
   logic [N_REQ-1:0]  pending_next;
   logic              overflow_next;

   prio_enc8_comb #(
      .HIGH_FIRST (HIGH_FIRST)
   ) u_enc (
      .in   (pending),
      .code (enc_code),
      .any  (enc_any)
   );

   // A new request on a bit being consumed this cycle is kept, not flagged.
   always_comb begin
      clr_mask = '0;
      if (out_valid && out_ready) clr_mask[out_code] = 1'b1;
      pending_next  = (pending & ~clr_mask) | req;
      overflow_next = |(req & pending & ~clr_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
         out_code  <= '0;
         state     <= ST_IDLE;
      end else begin
         pending  <= pending_next;
         overflow <= overflow_next;
         case (state)
            ST_IDLE: begin
               out_valid <= 1'b0;
               if (enc_any) begin
                  out_code  <= enc_code;
                  out_valid <= 1'b1;
                  state     <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prio_encoder83.sv
// Directed bench for prio_encoder83; a high-first and a low-first instance share stimulus.
module tb_prio_encoder83;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       out_ready;

   logic       valid_hi, ovf_hi;
   logic [2:0] code_hi;
   logic [7:0] pend_hi;
   logic       valid_lo, ovf_lo;
   logic [2:0] code_lo;
   logic [7:0] pend_lo;

   int checks;
   int failures;

   prio_encoder83 #(.HIGH_FIRST(1'b1)) u_hi (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .out_ready (out_ready),
      .out_valid (valid_hi),
      .out_code  (code_hi),
      .pending   (pend_hi),
      .overflow  (ovf_hi)
   );

   prio_encoder83 #(.HIGH_FIRST(1'b0)) u_lo (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .out_ready (out_ready),
      .out_valid (valid_lo),
      .out_code  (code_lo),
      .pending   (pend_lo),
      .overflow  (ovf_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled and inputs changed 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 8'h00; out_ready = 1'b0;
      step();
      step();
      checks++; if (pend_hi !== 8'h00) begin failures++; $display("FAIL reset_pending got=%h exp=00", pend_hi); end
      checks++; if (valid_hi !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_hi); end
      checks++; if (code_hi !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", code_hi); end
      checks++; if (ovf_hi !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", ovf_hi); end
      rst = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (pend_hi !== 8'h00 || valid_hi !== 1'b0 || ovf_hi !== 1'b0)
            begin failures++; $display("FAIL idle_quiet pend=%h valid=%b ovf=%b exp 00/0/0", pend_hi, valid_hi, ovf_hi); end
      end
   endtask

   task automatic test_single();
      req = 8'h04; out_ready = 1'b1;
      step();
      req = 8'h00;
      checks++; if (pend_hi !== 8'h04 || valid_hi !== 1'b0)
         begin failures++; $display("FAIL single_capture pend=%h valid=%b exp 04/0", pend_hi, valid_hi); end
      step();
      checks++; if (valid_hi !== 1'b1 || code_hi !== 3'd2)
         begin failures++; $display("FAIL single_present_hi valid=%b code=%0d exp 1/2", valid_hi, code_hi); end
      checks++; if (valid_lo !== 1'b1 || code_lo !== 3'd2)
         begin failures++; $display("FAIL single_present_lo valid=%b code=%0d exp 1/2", valid_lo, code_lo); end
      step();
      checks++; if (pend_hi !== 8'h00 || valid_hi !== 1'b0)
         begin failures++; $display("FAIL single_consumed pend=%h valid=%b exp 00/0", pend_hi, valid_hi); end
      step();
      checks++; if (valid_hi !== 1'b0)
         begin failures++; $display("FAIL single_stay_idle valid=%b exp 0", valid_hi); end
   endtask

   task automatic test_priority();
      logic [2:0] exp_hi [3];
      logic [2:0] exp_lo [3];
      exp_hi[0] = 3'd7; exp_hi[1] = 3'd4; exp_hi[2] = 3'd1;
      exp_lo[0] = 3'd1; exp_lo[1] = 3'd4; exp_lo[2] = 3'd7;
      req = 8'b1001_0010; out_ready = 1'b1;
      step();
      req = 8'h00;
      checks++; if (pend_hi !== 8'h92 || valid_hi !== 1'b0)
         begin failures++; $display("FAIL prio_capture pend=%h valid=%b exp 92/0", pend_hi, valid_hi); end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (valid_hi !== 1'b1 || code_hi !== exp_hi[k])
            begin failures++; $display("FAIL prio_hi_%0d valid=%b code=%0d exp 1/%0d", k, valid_hi, code_hi, exp_hi[k]); end
         checks++; if (valid_lo !== 1'b1 || code_lo !== exp_lo[k])
            begin failures++; $display("FAIL prio_lo_%0d valid=%b code=%0d exp 1/%0d", k, valid_lo, code_lo, exp_lo[k]); end
         step();
         checks++; if (valid_hi !== 1'b0 || valid_lo !== 1'b0)
            begin failures++; $display("FAIL prio_bubble_%0d valid_hi=%b valid_lo=%b exp 0/0", k, valid_hi, valid_lo); end
      end
      checks++; if (pend_hi !== 8'h00 || pend_lo !== 8'h00)
         begin failures++; $display("FAIL prio_drained pend_hi=%h pend_lo=%h exp 00/00", pend_hi, pend_lo); end
   endtask

   task automatic test_backpressure();
      req = 8'h01; out_ready = 1'b0;
      step();
      req = 8'h00;
      step();
      checks++; if (valid_hi !== 1'b1 || code_hi !== 3'd0)
         begin failures++; $display("FAIL bp_present valid=%b code=%0d exp 1/0", valid_hi, code_hi); end
      req = 8'h80;
      step();
      req = 8'h00;
      for (int k = 0; k < 3; k++) begin
         checks++; if (valid_hi !== 1'b1 || code_hi !== 3'd0 || pend_hi !== 8'h81)
            begin failures++; $display("FAIL bp_hold_%0d valid=%b code=%0d pend=%h exp 1/0/81", k, valid_hi, code_hi, pend_hi); end
         step();
      end
      out_ready = 1'b1;
      step();
      checks++; if (valid_hi !== 1'b0 || pend_hi !== 8'h80)
         begin failures++; $display("FAIL bp_release valid=%b pend=%h exp 0/80", valid_hi, pend_hi); end
      step();
      checks++; if (valid_hi !== 1'b1 || code_hi !== 3'd7)
         begin failures++; $display("FAIL bp_next valid=%b code=%0d exp 1/7", valid_hi, code_hi); end
      step();
      out_ready = 1'b0;
      checks++; if (pend_hi !== 8'h00 || valid_hi !== 1'b0)
         begin failures++; $display("FAIL bp_drained pend=%h valid=%b exp 00/0", pend_hi, valid_hi); end
   endtask

   task automatic test_overflow();
      req = 8'h08; out_ready = 1'b0;
      step();
      req = 8'h00;
      checks++; if (ovf_hi !== 1'b0)
         begin failures++; $display("FAIL ovf_first_req got=%b exp=0", ovf_hi); end
      step();
      checks++; if (valid_hi !== 1'b1 || code_hi !== 3'd3)
         begin failures++; $display("FAIL ovf_present valid=%b code=%0d exp 1/3", valid_hi, code_hi); end
      for (int k = 0; k < 2; k++) begin
         req = 8'h08;
         step();
         req = 8'h00;
         checks++; if (ovf_hi !== 1'b1 || pend_hi !== 8'h08)
            begin failures++; $display("FAIL ovf_pulse_%0d ovf=%b pend=%h exp 1/08", k, ovf_hi, pend_hi); end
         step();
         checks++; if (ovf_hi !== 1'b0)
            begin failures++; $display("FAIL ovf_clear_%0d got=%b exp=0", k, ovf_hi); end
      end
      req = 8'h08; out_ready = 1'b1;
      step();
      req = 8'h00;
      checks++; if (pend_hi !== 8'h08 || valid_hi !== 1'b0 || ovf_hi !== 1'b0)
         begin failures++; $display("FAIL set_wins pend=%h valid=%b ovf=%b exp 08/0/0", pend_hi, valid_hi, ovf_hi); end
      step();
      checks++; if (valid_hi !== 1'b1 || code_hi !== 3'd3)
         begin failures++; $display("FAIL set_wins_again valid=%b code=%0d exp 1/3", valid_hi, code_hi); end
      step();
      out_ready = 1'b0;
      checks++; if (pend_hi !== 8'h00)
         begin failures++; $display("FAIL set_wins_drain pend=%h exp 00", pend_hi); end
   endtask

   task automatic test_all_pending();
      req = 8'hFF; out_ready = 1'b1;
      step();
      req = 8'h00;
      for (int k = 0; k < 8; k++) begin
         step();
         checks++; if (valid_hi !== 1'b1 || code_hi !== 3'(7 - k))
            begin failures++; $display("FAIL all_hi_%0d valid=%b code=%0d exp 1/%0d", k, valid_hi, code_hi, 7 - k); end
         checks++; if (valid_lo !== 1'b1 || code_lo !== 3'(k))
            begin failures++; $display("FAIL all_lo_%0d valid=%b code=%0d exp 1/%0d", k, valid_lo, code_lo, k); end
         step();
      end
      step();
      checks++; if (pend_hi !== 8'h00 || valid_hi !== 1'b0 || pend_lo !== 8'h00 || valid_lo !== 1'b0)
         begin failures++; $display("FAIL all_idle pend_hi=%h valid_hi=%b pend_lo=%h valid_lo=%b exp 00/0", pend_hi, valid_hi, pend_lo, valid_lo); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      req = 8'hFF; out_ready = 1'b0;
      step();
      req = 8'h00;
      step();
      checks++; if (valid_hi !== 1'b1 || code_hi !== 3'd7 || pend_hi !== 8'hFF)
         begin failures++; $display("FAIL mid_setup valid=%b code=%0d pend=%h exp 1/7/ff", valid_hi, code_hi, pend_hi); end
      rst = 1'b1; out_ready = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (valid_hi !== 1'b0 || pend_hi !== 8'h00 || code_hi !== 3'd0 || ovf_hi !== 1'b0)
         begin failures++; $display("FAIL mid_reset valid=%b pend=%h code=%0d ovf=%b exp 0/00/0/0", valid_hi, pend_hi, code_hi, ovf_hi); end
      for (int k = 0; k < 2; k++) begin
         step();
         checks++; if (valid_hi !== 1'b0 || pend_hi !== 8'h00 || valid_lo !== 1'b0)
            begin failures++; $display("FAIL mid_after_%0d valid=%b pend=%h valid_lo=%b exp 0/00/0", k, valid_hi, pend_hi, valid_lo); end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      req = 8'h00;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_priority();
      test_backpressure();
      test_overflow();
      test_all_pending();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
